// File: rtl/alu_writeback_regs_if.sv
// Operand read, write-back and flag bus between control/ALU and the register file.
interface alu_writeback_regs_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = 2
);
  logic                  hold;
  logic [SEL_WIDTH-1:0]  rd_a_sel;
  logic [SEL_WIDTH-1:0]  rd_b_sel;
  logic [DATA_WIDTH-1:0] a_out;
  logic [DATA_WIDTH-1:0] b_out;
  logic                  wr_en;
  logic [SEL_WIDTH-1:0]  wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  flags_we;
  logic                  c_in;
  logic                  z_in;
  logic                  s_in;
  logic                  carry_out;
  logic                  zero_out;
  logic                  sign_out;
  logic                  wb_busy;

  // Control/ALU side
  modport master (
    output hold, rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data,
    output flags_we, c_in, z_in, s_in,
    input  a_out, b_out, carry_out, zero_out, sign_out, wb_busy
  );

  // Register file side
  modport slave (
    input  hold, rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data,
    input  flags_we, c_in, z_in, s_in,
    output a_out, b_out, carry_out, zero_out, sign_out, wb_busy
  );
endinterface

// File: rtl/alu_writeback_regs.sv
// General register file with a one-deep registered write-back stage and the
// architectural C/Z/S flag register feeding the ALU.
// Optional macro WB_BYPASS_EN: forward the pending write-back value to reads.
module alu_writeback_regs #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input logic                clk,
  input logic                reset,
  alu_writeback_regs_if.slave bus
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wb_valid;
  logic [SEL_WIDTH-1:0]  wb_sel;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  carry_q;
  logic                  zero_q;
  logic                  sign_q;
  logic [DATA_WIDTH-1:0] a_c;
  logic [DATA_WIDTH-1:0] b_c;

  // Write-back stage, array commit and flags; hold freezes all of it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wb_valid <= 1'b0;
      wb_sel   <= '0;
      wb_data  <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else if (!bus.hold) begin
      // pending value commits while the new one is captured, so a
      // same-register back-to-back write loses nothing
      if (wb_valid) regs[wb_sel] <= wb_data;
      wb_valid <= bus.wr_en;
      if (bus.wr_en) begin
        wb_sel  <= bus.wr_sel;
        wb_data <= bus.wr_data;
      end
      if (bus.flags_we) begin
        carry_q <= bus.c_in;
        zero_q  <= bus.z_in;
        sign_q  <= bus.s_in;
      end
    end
  end

  // Combinational operand reads, optionally forwarding the pending write
  always_comb begin
    a_c = regs[bus.rd_a_sel];
    b_c = regs[bus.rd_b_sel];
`ifdef WB_BYPASS_EN
    if (wb_valid && (wb_sel == bus.rd_a_sel)) a_c = wb_data;
    if (wb_valid && (wb_sel == bus.rd_b_sel)) b_c = wb_data;
`endif
  end

  assign bus.a_out     = a_c;
  assign bus.b_out     = b_c;
  assign bus.carry_out = carry_q;
  assign bus.zero_out  = zero_q;
  assign bus.sign_out  = sign_q;
  assign bus.wb_busy   = wb_valid;

endmodule

// File: tb/tb_alu_writeback_regs.sv
// Scoreboard bench for alu_writeback_regs: the driver predicts each cycle's
// outputs from a write-history model, the monitor compares them.
module tb_alu_writeback_regs;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;

  alu_writeback_regs_if #(.DATA_WIDTH(8), .SEL_WIDTH(2)) bus ();

  alu_writeback_regs #(.NUM_REGS(4), .DATA_WIDTH(8), .SEL_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
    logic       s;
    logic       busy;
  } exp_t;

  // An accepted write, stamped with the advancing-edge number that took it
  typedef struct {
    int         k;
    logic [1:0] sel;
    logic [7:0] data;
  } wr_t;

  exp_t expq[$];
  wr_t  hist[$];
  int   n_adv;
  logic mc, mz, ms;
  int   total;
  int   bad;

  // A write taken on advancing edge k lands in the array on edge k+1;
  // with forwarding it is readable right after edge k.
  function automatic logic [7:0] m_read(input logic [1:0] sel);
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].sel == sel && (hist[i].k < n_adv || (BYP && hist[i].k == n_adv)))
        return hist[i].data;
    end
    return 8'h00;
  endfunction

  function automatic logic m_busy();
    return (hist.size() > 0) && (hist[hist.size()-1].k == n_adv);
  endfunction

  task automatic m_reset();
    hist.delete();
    n_adv = 0;
    mc = 1'b0;
    mz = 1'b0;
    ms = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, predict its outputs, then advance the model over the edge
  task automatic cyc(input logic rst, input logic hd, input logic [1:0] ra,
                     input logic [1:0] rb, input logic we, input logic [1:0] ws,
                     input logic [7:0] wd, input logic fwe, input logic c,
                     input logic z, input logic s);
    exp_t e;
    wr_t  w;
    @(negedge clk);
    reset        = rst;
    bus.hold     = hd;
    bus.rd_a_sel = ra;
    bus.rd_b_sel = rb;
    bus.wr_en    = we;
    bus.wr_sel   = ws;
    bus.wr_data  = wd;
    bus.flags_we = fwe;
    bus.c_in     = c;
    bus.z_in     = z;
    bus.s_in     = s;
    e.a    = m_read(ra);
    e.b    = m_read(rb);
    e.c    = mc;
    e.z    = mz;
    e.s    = ms;
    e.busy = m_busy();
    expq.push_back(e);
    if (rst) begin
      m_reset();
    end else if (!hd) begin
      n_adv++;
      if (we) begin
        w.k    = n_adv;
        w.sel  = ws;
        w.data = wd;
        hist.push_back(w);
      end
      if (fwe) begin
        mc = c;
        mz = z;
        ms = s;
      end
    end
  endtask

  task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
    cyc(1'b0, 1'b0, ra, rb, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the predicted record
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("a_out",     bus.a_out,               e.a);
        check("b_out",     bus.b_out,               e.b);
        check("carry_out", 8'(bus.carry_out),       8'(e.c));
        check("zero_out",  8'(bus.zero_out),        8'(e.z));
        check("sign_out",  8'(bus.sign_out),        8'(e.s));
        check("wb_busy",   8'(bus.wb_busy),         8'(e.busy));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.hold = 1'b0;
    bus.rd_a_sel = 2'd0;
    bus.rd_b_sel = 2'd0;
    bus.wr_en = 1'b0;
    bus.wr_sel = 2'd0;
    bus.wr_data = 8'h00;
    bus.flags_we = 1'b0;
    bus.c_in = 1'b0;
    bus.z_in = 1'b0;
    bus.s_in = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();

    // reset state of every register and the flags
    idle(2'd0, 2'd1);
    idle(2'd2, 2'd3);

    // write R2=0x5A, observe latency to the read port
    cyc(1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(2'd2, 2'd2);

    // back-to-back writes to R1
    cyc(1'b0, 1'b0, 2'd1, 2'd2, 1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd1, 2'd2, 1'b1, 2'd1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(2'd1, 2'd1);

    // pending R3=0x33 held for three cycles with a flag write that is dropped
    cyc(1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 2'd3, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 2'd0, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) idle(2'd3, 2'd0);

    // flags only, no register write
    cyc(1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 2'd1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) idle(2'd1, 2'd3);

    // reset on the commit edge of a pending R0 write
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) idle(2'd0, 2'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 30),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end
    idle(2'd0, 2'd1);
    idle(2'd2, 2'd3);

    @(negedge clk);
    #3;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
